// File: rtl/score_pkg.sv
// Shared types and constants for the score_hex_display block:
// FSM state encoding, active-low 7-segment codes and a power-of-ten helper.
package score_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StConv,
    StCommit
  } state_t;

  // Active-low {dp,g,f,e,d,c,b,a}; dp always off.
  localparam logic [7:0] Seg7Code0  = 8'hC0;
  localparam logic [7:0] Seg7Code1  = 8'hF9;
  localparam logic [7:0] Seg7Code2  = 8'hA4;
  localparam logic [7:0] Seg7Code3  = 8'hB0;
  localparam logic [7:0] Seg7Code4  = 8'h99;
  localparam logic [7:0] Seg7Code5  = 8'h92;
  localparam logic [7:0] Seg7Code6  = 8'h82;
  localparam logic [7:0] Seg7Code7  = 8'hF8;
  localparam logic [7:0] Seg7Code8  = 8'h80;
  localparam logic [7:0] Seg7Code9  = 8'h90;
  localparam logic [7:0] Seg7Blank  = 8'hFF;

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned r;
    r = 1;
    for (int unsigned i = 0; i < n; i++) begin
      r = r * 10;
    end
    return r;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// One BCD nibble to an active-low 7-segment code; non-decimal nibbles and
// blanked digits render dark.
module bcd_to_seg7
  import score_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [7:0] seg
);

  always_comb begin
    seg = Seg7Blank;
    if (!blank) begin
      case (nibble)
        4'd0:    seg = Seg7Code0;
        4'd1:    seg = Seg7Code1;
        4'd2:    seg = Seg7Code2;
        4'd3:    seg = Seg7Code3;
        4'd4:    seg = Seg7Code4;
        4'd5:    seg = Seg7Code5;
        4'd6:    seg = Seg7Code6;
        4'd7:    seg = Seg7Code7;
        4'd8:    seg = Seg7Code8;
        4'd9:    seg = Seg7Code9;
        default: seg = Seg7Blank;
      endcase
    end
  end

endmodule

// File: rtl/score_hex_display.sv
// Samples a binary score, converts it to BCD with an iterative double-dabble
// engine, tracks the high score and drives the active-low HEX digit bank.
module score_hex_display
  import score_pkg::*;
#(
  parameter int unsigned BIN_W  = 32,
  parameter int unsigned DIGITS = 6
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  input  logic                  start,
  input  logic [BIN_W-1:0]      value,
  input  logic                  clear_high,
  input  logic                  show_high,
  input  logic                  blank_lz,
  output logic                  busy,
  output logic                  done,
  output logic                  overflow,
  output logic                  new_high,
  output logic [4*DIGITS-1:0]   bcd,
  output logic [4*DIGITS-1:0]   high_bcd,
  output logic [8*DIGITS-1:0]   seg
);

  localparam int unsigned BcdW = 4 * DIGITS;
  localparam int unsigned ShW  = BcdW + BIN_W;
  localparam int unsigned CntW = $clog2(BIN_W + 1);
  localparam longint unsigned MaxVal = pow10(DIGITS) - 1;

  state_t               state_q, state_d;
  logic [ShW-1:0]       sh_q, sh_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [BIN_W-1:0]     sat_q, sat_d;
  logic                 ovf_q, ovf_d;
  logic [BcdW-1:0]      bcd_q, bcd_d;
  logic [BcdW-1:0]      high_bcd_q, high_bcd_d;
  logic [BIN_W-1:0]     high_bin_q, high_bin_d;
  logic                 new_high_q, new_high_d;
  logic                 overflow_q, overflow_d;
  logic                 done_q, done_d;

  logic                 too_big;
  logic [BIN_W-1:0]     sat_val;
  logic [ShW-1:0]       sh_adj;
  logic [ShW-1:0]       sh_shift;

  // Compare in 64 bits so MAX may exceed the input width.
  assign too_big = 64'(value) > 64'(MaxVal);
  assign sat_val = too_big ? BIN_W'(MaxVal) : value;

  always_comb begin
    sh_adj = sh_q;
    for (int d = 0; d < int'(DIGITS); d++) begin
      if (sh_adj[BIN_W+4*d +: 4] >= 4'd5) begin
        sh_adj[BIN_W+4*d +: 4] = sh_adj[BIN_W+4*d +: 4] + 4'd3;
      end
    end
    sh_shift = {sh_adj[ShW-2:0], 1'b0};
  end

  always_comb begin
    state_d    = state_q;
    sh_d       = sh_q;
    cnt_d      = cnt_q;
    sat_d      = sat_q;
    ovf_d      = ovf_q;
    bcd_d      = bcd_q;
    high_bcd_d = high_bcd_q;
    high_bin_d = high_bin_q;
    new_high_d = new_high_q;
    overflow_d = overflow_q;
    done_d     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (start) begin
          sat_d      = sat_val;
          ovf_d      = too_big;
          sh_d       = {{BcdW{1'b0}}, sat_val};
          cnt_d      = CntW'(BIN_W);
          new_high_d = 1'b0;
          state_d    = StConv;
        end
      end
      StConv: begin
        sh_d  = sh_shift;
        cnt_d = cnt_q - CntW'(1);
        if (cnt_q == CntW'(1)) begin
          state_d = StCommit;
        end
      end
      StCommit: begin
        bcd_d      = sh_q[ShW-1 -: BcdW];
        done_d     = 1'b1;
        overflow_d = ovf_q;
        if (sat_q > high_bin_q) begin
          high_bin_d = sat_q;
          high_bcd_d = sh_q[ShW-1 -: BcdW];
          new_high_d = 1'b1;
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Clear overrides any high-score update landing on the same edge.
    if (clear_high) begin
      high_bin_d = '0;
      high_bcd_d = '0;
      new_high_d = 1'b0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= StIdle;
      sh_q       <= '0;
      cnt_q      <= '0;
      sat_q      <= '0;
      ovf_q      <= 1'b0;
      bcd_q      <= '0;
      high_bcd_q <= '0;
      high_bin_q <= '0;
      new_high_q <= 1'b0;
      overflow_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      sh_q       <= sh_d;
      cnt_q      <= cnt_d;
      sat_q      <= sat_d;
      ovf_q      <= ovf_d;
      bcd_q      <= bcd_d;
      high_bcd_q <= high_bcd_d;
      high_bin_q <= high_bin_d;
      new_high_q <= new_high_d;
      overflow_q <= overflow_d;
      done_q     <= done_d;
    end
  end

  assign busy     = (state_q != StIdle);
  assign done     = done_q;
  assign overflow = overflow_q;
  assign new_high = new_high_q;
  assign bcd      = bcd_q;
  assign high_bcd = high_bcd_q;

  logic [BcdW-1:0]   disp;
  logic [DIGITS-1:0] blank_vec;

  assign disp = show_high ? high_bcd_q : bcd_q;

  // Walk from the most significant digit down; blank until a nonzero digit.
  always_comb begin
    logic nz;
    nz        = 1'b0;
    blank_vec = '0;
    for (int i = int'(DIGITS) - 1; i >= 0; i--) begin
      nz           = nz | (disp[4*i +: 4] != 4'd0);
      blank_vec[i] = blank_lz && (i != 0) && !nz;
    end
  end

  for (genvar g = 0; g < int'(DIGITS); g++) begin : g_digit
    bcd_to_seg7 u_seg (
      .nibble (disp[4*g +: 4]),
      .blank  (blank_vec[g]),
      .seg    (seg[8*g +: 8])
    );
  end

endmodule

// File: tb/tb_score_hex_display.sv
// Directed bench for score_hex_display at default parameters (32-bit input,
// six digits) with hand-computed BCD and segment expectations.
module tb_score_hex_display;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b1;
  logic        start = 1'b0;
  logic [31:0] value = '0;
  logic        clear_high = 1'b0;
  logic        show_high = 1'b0;
  logic        blank_lz = 1'b1;
  logic        busy, done, overflow, new_high;
  logic [23:0] bcd, high_bcd;
  logic [47:0] seg;

  int n_tests = 0;
  int n_fail  = 0;

  score_hex_display #(
    .BIN_W  (32),
    .DIGITS (6)
  ) dut (
    .Clk        (Clk),
    .Reset_n    (Reset_n),
    .start      (start),
    .value      (value),
    .clear_high (clear_high),
    .show_high  (show_high),
    .blank_lz   (blank_lz),
    .busy       (busy),
    .done       (done),
    .overflow   (overflow),
    .new_high   (new_high),
    .bcd        (bcd),
    .high_bcd   (high_bcd),
    .seg        (seg)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Runs one conversion; optionally re-pulses start or clear_high n edges after
  // the accepting edge. Checks latency, busy length and a single done pulse.
  task automatic run_conv(input string tag, input logic [31:0] v,
                          input int restart_at, input int clear_at);
    int n;
    int busy_cnt;
    int extra;
    value = v;
    start = 1'b1;
    tick();
    start    = 1'b0;
    n        = 0;
    busy_cnt = 0;
    while (!done && n < 100) begin
      if (busy) busy_cnt++;
      tick();
      n++;
      start      = (n == restart_at);
      if (start) value = 32'd55;
      clear_high = (n == clear_at);
    end
    start      = 1'b0;
    clear_high = 1'b0;
    check_eq({tag, "_latency"}, 64'(n), 64'd33);
    check_eq({tag, "_busy_cycles"}, 64'(busy_cnt), 64'd33);
    check_eq({tag, "_busy_after"}, 64'(busy), 64'd0);
    // Leave state untouched for the caller: sample extra pulses without moving inputs.
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) extra++;
    end
    check_eq({tag, "_extra_done"}, 64'(extra), 64'd0);
  endtask

  initial begin
    int seen;

    #2 Reset_n = 1'b0;
    #1;
    check_eq("rst_bcd", 64'(bcd), 64'h0);
    check_eq("rst_busy", 64'(busy), 64'h0);
    check_eq("rst_done", 64'(done), 64'h0);
    check_eq("rst_ovf", 64'(overflow), 64'h0);
    check_eq("rst_new_high", 64'(new_high), 64'h0);
    check_eq("rst_high_bcd", 64'(high_bcd), 64'h0);
    check_eq("rst_seg_blank", 64'(seg), 64'hFFFF_FFFF_FFC0);
    blank_lz = 1'b0;
    #1;
    check_eq("rst_seg_noblank", 64'(seg), 64'hC0C0_C0C0_C0C0);
    tick();
    tick();
    Reset_n = 1'b1;
    tick();

    run_conv("c123456", 32'd123456, -1, -1);
    check_eq("c123456_bcd", 64'(bcd), 64'h123456);
    check_eq("c123456_seg", 64'(seg), 64'hF9A4_B099_9282);
    check_eq("c123456_ovf", 64'(overflow), 64'h0);

    run_conv("c1500000", 32'd1500000, -1, -1);
    check_eq("c1500000_bcd", 64'(bcd), 64'h999999);
    check_eq("c1500000_ovf", 64'(overflow), 64'h1);

    blank_lz = 1'b1;
    run_conv("c7", 32'd7, -1, -1);
    check_eq("c7_bcd", 64'(bcd), 64'h000007);
    check_eq("c7_ovf", 64'(overflow), 64'h0);
    check_eq("c7_seg", 64'(seg), 64'hFFFF_FFFF_FFF8);

    clear_high = 1'b1;
    tick();
    clear_high = 1'b0;
    check_eq("clr_high_bcd", 64'(high_bcd), 64'h0);
    check_eq("clr_new_high", 64'(new_high), 64'h0);

    run_conv("c500", 32'd500, -1, -1);
    check_eq("c500_high_bcd", 64'(high_bcd), 64'h000500);
    check_eq("c500_new_high", 64'(new_high), 64'h1);
    run_conv("c300", 32'd300, -1, -1);
    check_eq("c300_bcd", 64'(bcd), 64'h000300);
    check_eq("c300_high_bcd", 64'(high_bcd), 64'h000500);
    check_eq("c300_new_high", 64'(new_high), 64'h0);
    show_high = 1'b1;
    #1;
    check_eq("show_high_seg", 64'(seg), 64'hFFFF_FF92_C0C0);
    show_high = 1'b0;
    #1;
    check_eq("show_last_seg", 64'(seg), 64'hFFFF_FFB0_C0C0);

    run_conv("c1234_restart", 32'd1234, 10, -1);
    check_eq("c1234_bcd", 64'(bcd), 64'h001234);

    run_conv("c900_clear", 32'd900, -1, 32);
    check_eq("c900_bcd", 64'(bcd), 64'h000900);
    check_eq("c900_high_bcd", 64'(high_bcd), 64'h0);
    check_eq("c900_new_high", 64'(new_high), 64'h0);

    value = 32'd77;
    start = 1'b1;
    tick();
    start = 1'b0;
    repeat (15) tick();
    check_eq("abort_busy_before", 64'(busy), 64'h1);
    Reset_n = 1'b0;
    #1;
    check_eq("abort_busy_now", 64'(busy), 64'h0);
    seen = 0;
    repeat (3) begin
      tick();
      if (done) seen++;
    end
    Reset_n = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done) seen++;
    end
    check_eq("abort_no_done", 64'(seen), 64'd0);
    check_eq("abort_bcd", 64'(bcd), 64'h0);

    run_conv("c42", 32'd42, -1, -1);
    check_eq("c42_bcd", 64'(bcd), 64'h000042);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/score_hex_display.md
# score_hex_display

Sequential score formatter for the HEX bank on the MAX10 board. It samples a binary score on a start pulse and converts it to packed BCD using an iterative shift-add-3 (double dabble) engine. It tracks a high score and drives DIGITS active-low 7-segment outputs with optional leading-zero blanking. It replaces the fixed four-digit, software-fed HEX path with a parametrised hardware path that the top level connects to `distance_sum` / `score_num`.

## Interface
- BIN_W, 32: width of the binary input score.
- DIGITS, 6: number of BCD digits and HEX displays, 1..8.
- Clk  in  1  system clock (MAX10_CLK1_50).
- Reset_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle request to sample `value`; ignored while busy.
- value  in  BIN_W  unsigned score.
- clear_high  in  1  one-cycle request to zero the high score.
- show_high  in  1  1 = `seg` shows the high score; 0 = `seg` shows the last converted score.
- blank_lz  in  1  1 = blank leading zeros.
- busy  out  1  conversion in progress.
- done  out  1  one-cycle pulse when `bcd` updates.
- overflow  out  1  last sample exceeded MAX and was saturated.
- new_high  out  1  last commit raised the high score; sticky.
- bcd  out  4*DIGITS  last converted score; digit i is `[4i+3:4i]`.
- high_bcd  out  4*DIGITS  high score in BCD.
- seg  out  8*DIGITS  active-low `{dp,g,f,e,d,c,b,a}`; digit i is `[8i+7:8i]`; dp is always 1.

## Operation
- MAX = 10^DIGITS − 1, a localparam. If MAX ≥ 2^BIN_W, overflow can never assert.
- FSM states: IDLE, CONV, COMMIT.
- IDLE → CONV on `start`:
  - latch `sat = (value > MAX) ? MAX : value`;
  - latch `ovf = (value > MAX)`;
  - load shift register `{BCD=0, sat}`, set iteration counter = BIN_W, clear new_high.
- CONV: per cycle, add 3 to every BCD nibble ≥ 5, then shift the combined register left by 1 and decrement the counter. Go to COMMIT when the counter reaches 0 after the shift.
- COMMIT: 
  - write `bcd`, assert `done`, write `overflow = ovf`;
  - if `sat > high_bin`, write `high_bin = sat`, `high_bcd = bcd`, `new_high = 1`;
  - return to IDLE.
- `start` while in CONV or COMMIT is dropped; there is no queueing.
- `clear_high`: `high_bin`, `high_bcd` and `new_high` become 0 on the next edge. If it coincides with COMMIT, the clear wins: the high score stays 0, `new_high` = 0, and `bcd`/`done` still update.
- Seg decode is combinational from `show_high ? high_bcd : bcd`.
  - Codes: 0=C0, 1=F9, 2=A4, 3=B0, 4=99, 5=92, 6=82, 7=F8, 8=80, 9=90. Nibble values 10–15 decode to FF.
  - Blanking: when `blank_lz` = 1, digit i>0 outputs FF if it and all higher digits are 0. Digit 0 is never blanked.

## Timing
- Reset (asynchronous, immediate): state IDLE, busy 0, done 0, overflow 0, new_high 0, bcd 0, high_bcd 0, high_bin 0, counter 0.
  - Resulting seg: digit0 = C0; other digits = FF if `blank_lz` = 1, else C0.
- Start sampled at edge 0. `busy` = 1 from edge 0 through edge BIN_W+1.
- CONV occupies edges 1..BIN_W. COMMIT is edge BIN_W+1, where `done` rises for exactly one cycle and busy falls.
- Latency from start to done is BIN_W+1 cycles (33 at default).
- Reset asserted mid-conversion aborts it with no done pulse.
- `seg` follows `show_high` and `blank_lz` combinationally with zero latency.
- One conversion per VGA frame is the intended rate. Throughput is 1 per BIN_W+2 cycles, since start is accepted again on the cycle after COMMIT.

## Structure
- Package `score_pkg`: state enum (IDLE, CONV, COMMIT) and the SEG7 code constants.
- Sub-module `bcd_to_seg7`: 4-bit nibble plus blank input → 8-bit active-low code. Instantiate DIGITS copies via generate.
- Blanking chain, FSM, shift register and high-score logic live in the top block.

## Test plan
- Reset with `blank_lz` = 1 → bcd 0, busy 0, `seg[7:0]` = C0, `seg[47:8]` all FF; with `blank_lz` = 0 → every digit C0.
- `start`, `value` = 123456 → busy for 33 cycles, single done pulse at cycle 33, bcd = 0x123456, seg digits 5..0 = F9, A4, B0, 99, 92, 82, overflow 0.
- `value` = 1,500,000 → bcd = 0x999999, overflow 1; next `value` = 7 → bcd = 0x000007, overflow 0, `seg` = C0-blanked except digit0 = F8.
- High score: start 500, then start 300 → high_bcd = 0x000500; new_high = 1 after the first commit, 0 after the second; `show_high` = 1 → digits 2..0 = 92, C0, C0.
- Second `start` at cycle 10 of a conversion → ignored, exactly one done. `clear_high` on the COMMIT cycle of value 900 → high_bcd 0, new_high 0, bcd = 0x000900.
- Reset_n low at cycle 15 of a conversion → busy 0 immediately, no done. Fresh start of 42 after release → bcd = 0x000042.
